// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg: shared types and response codes for the HyperBus read-path adapter.
package hyperbus_pkg;

   typedef enum logic [1:0] {Idle, Fill, Send} hyper_r_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/hyperbus_phy2r.sv
// hyperbus_phy2r: adapts the HyperBus PHY read word stream to AXI R beats,
// splitting words into narrow beats or packing them into wide beats by address.
module hyperbus_phy2r
   import hyperbus_pkg::*;
#(
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned BurstLength  = 8,
   parameter int unsigned NumPhys      = 2,
   parameter int unsigned AddrWidth    = $clog2(AxiDataWidth/8)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    trans_handshake,
   input  logic                    is_a_write,
   input  logic [AddrWidth-1:0]    start_addr,
   input  logic [2:0]              size,
   input  logic [BurstLength-1:0]  len,
   input  logic                    phy_valid_i,
   output logic                    phy_ready_o,
   input  logic [16*NumPhys-1:0]   phy_data_i,
   input  logic                    phy_err_i,
   output logic                    axi_valid_o,
   input  logic                    axi_ready_i,
   output logic [AxiDataWidth-1:0] axi_data_o,
   output logic [1:0]              axi_resp_o,
   output logic                    axi_last_o
);

   localparam int unsigned PhyWidth = 16*NumPhys;
   localparam int unsigned PhyBytes = 2*NumPhys;
   localparam int unsigned PhyLog   = $clog2(PhyBytes);
   localparam logic [AddrWidth-1:0] PhyStep = AddrWidth'(PhyBytes);
   localparam logic [AddrWidth-1:0] PhyMask = AddrWidth'(PhyBytes-1);

   hyper_r_state_t          r_state;
   logic [AddrWidth-1:0]    r_byte_idx;
   logic [2:0]              r_size;
   logic [BurstLength-1:0]  r_len;
   logic [BurstLength-1:0]  r_beat_cnt;
   logic [AxiDataWidth-1:0] r_buf;
   logic                    r_err;

   logic                           w_narrow;
   logic                           w_last;
   logic                           w_wide_done;
   logic                           w_narrow_stay;
   logic [AddrWidth-1:0]           w_step;
   logic [AddrWidth-1:0]           w_mask;
   logic [AddrWidth-1:0]           w_wide_idx;
   logic [AddrWidth-1:0]           w_narrow_idx;
   logic [AddrWidth-PhyLog-1:0]    w_lane;

   always_comb begin
      w_narrow      = r_size < 3'(PhyLog);
      w_step        = AddrWidth'(1) << r_size;
      w_mask        = w_step - AddrWidth'(1);
      w_lane        = r_byte_idx[AddrWidth-1:PhyLog];
      w_wide_idx    = (r_byte_idx & ~PhyMask) + PhyStep;
      // a wide beat is complete once the next word starts a new beat or wraps the AXI word
      w_wide_done   = ((w_wide_idx & w_mask) == '0) || (w_wide_idx[AddrWidth-1:PhyLog] == '0);
      w_narrow_idx  = (r_byte_idx & ~w_mask) + w_step;
      w_narrow_stay = w_narrow && ((w_narrow_idx & PhyMask) != '0);
      w_last        = r_beat_cnt == r_len;
   end

   assign phy_ready_o = r_state == Fill;
   assign axi_valid_o = r_state == Send;
   assign axi_last_o  = axi_valid_o && w_last;
   assign axi_resp_o  = r_err ? RESP_SLVERR : RESP_OKAY;
   assign axi_data_o  = r_buf;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= Idle;
         r_byte_idx <= '0;
         r_size     <= '0;
         r_len      <= '0;
         r_beat_cnt <= '0;
         r_buf      <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            Idle: if (trans_handshake && !is_a_write) begin
               r_byte_idx <= start_addr;
               r_size     <= size;
               r_len      <= len;
               r_beat_cnt <= '0;
               r_buf      <= '0;
               r_err      <= 1'b0;
               r_state    <= Fill;
            end
            Fill: if (phy_valid_i) begin
               r_buf[w_lane*PhyWidth +: PhyWidth] <= phy_data_i;
               r_err <= r_err | phy_err_i;
               if (w_narrow) r_state <= Send;
               else begin
                  r_byte_idx <= w_wide_idx;
                  if (w_wide_done) r_state <= Send;
               end
            end
            Send: if (axi_ready_i) begin
               r_beat_cnt <= r_beat_cnt + 1'b1;
               r_err      <= 1'b0;
               if (w_narrow) r_byte_idx <= w_narrow_idx;
               if (w_last) r_state <= Idle;
               else if (!w_narrow_stay) begin
                  r_state <= Fill;
                  r_buf   <= '0;
               end
            end
            default: r_state <= Idle;
         endcase
      end
   end

   a_handshake_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
      !(trans_handshake && r_state != Idle));

endmodule

// File: tb/tb_hyperbus_phy2r.sv
// tb_hyperbus_phy2r: directed and randomized bursts checked against a byte-level
// model of which PHY words and bytes each AXI beat must carry.
module tb_hyperbus_phy2r;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        trans_handshake = 1'b0;
   logic        is_a_write = 1'b0;
   logic [2:0]  start_addr = '0;
   logic [2:0]  size = '0;
   logic [7:0]  len = '0;
   logic        phy_valid_i = 1'b0;
   logic        phy_ready_o;
   logic [31:0] phy_data_i = '0;
   logic        phy_err_i = 1'b0;
   logic        axi_valid_o;
   logic        axi_ready_i = 1'b0;
   logic [63:0] axi_data_o;
   logic [1:0]  axi_resp_o;
   logic        axi_last_o;

   hyperbus_phy2r #(.AxiDataWidth(64), .BurstLength(8), .NumPhys(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .trans_handshake(trans_handshake), .is_a_write(is_a_write),
      .start_addr(start_addr), .size(size), .len(len), .phy_valid_i(phy_valid_i),
      .phy_ready_o(phy_ready_o), .phy_data_i(phy_data_i), .phy_err_i(phy_err_i),
      .axi_valid_o(axi_valid_o), .axi_ready_i(axi_ready_i), .axi_data_o(axi_data_o),
      .axi_resp_o(axi_resp_o), .axi_last_o(axi_last_o)
   );

   always #5 clk_i = ~clk_i;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] q_words [64];
   logic        q_err [64];
   int          nwords;

   logic [63:0] o_data [64];
   logic [1:0]  o_resp [64];
   logic        o_last [64];
   int o_beats, o_pops, o_extra, o_overlap, o_latbad, o_unstable;
   bit o_timeout;

   logic [63:0] e_data [64];
   logic [1:0]  e_resp [64];
   logic        e_last [64];
   int e_beats, e_pops;

   task automatic clear_q();
      for (int i = 0; i < 64; i++) begin
         q_words[i] = '0;
         q_err[i] = 1'b0;
      end
      nwords = 0;
   endtask

   function automatic logic [7:0] mem_byte(input int b, input int base);
      logic [31:0] w;
      w = q_words[(b - base) / 4];
      return w[((b - base) % 4) * 8 +: 8];
   endfunction

   // Byte-level reference: beat i covers [lo, lo+2^size); narrow beats expose their whole PHY word.
   task automatic model(input int a, input int s, input int l);
      int base, addr, nb, lo, hi, cons, first;
      logic [63:0] d;
      logic e;
      base = a & ~3;
      addr = a;
      cons = base / 4 - 1;
      for (int i = 0; i <= l; i++) begin
         nb = 1 << s;
         lo = addr & ~(nb - 1);
         hi = lo + nb - 1;
         d = '0;
         e = 1'b0;
         if (s >= 2) begin
            for (int b = lo; b <= hi; b++) if (b >= base) d[(b % 8) * 8 +: 8] = mem_byte(b, base);
         end else begin
            for (int b = lo & ~3; b < (lo & ~3) + 4; b++) d[(b % 8) * 8 +: 8] = mem_byte(b, base);
         end
         first = (lo > base ? lo : base) / 4;
         for (int w = first; w <= hi / 4; w++) if (w > cons) begin
            e = e | q_err[w - base / 4];
            cons = w;
         end
         e_data[i] = d;
         e_resp[i] = e ? 2'b10 : 2'b00;
         e_last[i] = (i == l);
         addr = lo + nb;
      end
      e_beats = l + 1;
      e_pops = cons - base / 4 + 1;
   endtask

   task automatic run_burst(input logic [2:0] a, input logic [2:0] s, input logic [7:0] l,
                            input int stall0, input bit rnd);
      int cyc, stall;
      bit prev_valid, prev_pop, held;
      logic [63:0] hd;
      logic [1:0] hr;
      logic hl;
      o_beats = 0; o_pops = 0; o_extra = 0; o_overlap = 0; o_latbad = 0; o_unstable = 0;
      o_timeout = 0;
      @(negedge clk_i);
      trans_handshake = 1'b1; is_a_write = 1'b0; start_addr = a; size = s; len = l;
      @(negedge clk_i);
      trans_handshake = 1'b0;
      cyc = 0; stall = stall0; prev_valid = 0; prev_pop = 0; held = 0;
      hd = '0; hr = '0; hl = 1'b0;
      while (o_beats < int'(l) + 1) begin
         if (cyc == 400) begin
            o_timeout = 1;
            break;
         end
         phy_valid_i = (o_pops < nwords) && (!rnd || $urandom_range(0, 3) != 0);
         phy_data_i = q_words[o_pops % 64];
         phy_err_i = q_err[o_pops % 64];
         axi_ready_i = (stall > 0) ? 1'b0 : (!rnd || $urandom_range(0, 2) != 0);
         if (axi_valid_o && stall > 0) stall--;
         if (axi_valid_o && phy_ready_o) o_overlap++;
         if (axi_valid_o && !prev_valid && !prev_pop) o_latbad++;
         if (held && (axi_data_o !== hd || axi_resp_o !== hr || axi_last_o !== hl)) o_unstable++;
         held = axi_valid_o && !axi_ready_i;
         hd = axi_data_o; hr = axi_resp_o; hl = axi_last_o;
         prev_valid = axi_valid_o;
         prev_pop = phy_valid_i && phy_ready_o;
         if (axi_valid_o && axi_ready_i && o_beats < 64) begin
            o_data[o_beats] = axi_data_o;
            o_resp[o_beats] = axi_resp_o;
            o_last[o_beats] = axi_last_o;
            o_beats++;
         end
         if (prev_pop) o_pops++;
         @(negedge clk_i);
         cyc++;
      end
      phy_valid_i = 1'b1;
      phy_data_i = 32'hDEADBEEF;
      axi_ready_i = 1'b0;
      repeat (4) begin
         if (phy_ready_o) o_extra++;
         @(negedge clk_i);
      end
      phy_valid_i = 1'b0;
      phy_err_i = 1'b0;
   endtask

   task automatic load_s1();
      clear_q();
      q_words[0] = 32'h11111111; q_words[1] = 32'h22222222;
      q_words[2] = 32'h33333333; q_words[3] = 32'h44444444;
      nwords = 4;
   endtask

   task automatic test_reset();
      tests_run++;
      if ({phy_ready_o, axi_valid_o, axi_last_o} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got ready/valid/last=%b want 000", {phy_ready_o, axi_valid_o, axi_last_o});
      end
      tests_run++;
      if (axi_data_o !== 64'h0 || axi_resp_o !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_data: got data=%h resp=%b want 0/00", axi_data_o, axi_resp_o);
      end
   endtask

   task automatic test_wide_aligned();
      logic [63:0] want [2];
      load_s1();
      want[0] = 64'h2222222211111111; want[1] = 64'h4444444433333333;
      run_burst(3'd0, 3'd3, 8'd1, 0, 0);
      tests_run++;
      if (o_timeout !== 0 || o_beats !== 2) begin
         tests_failed++;
         $display("FAIL wide_beats: got %0d beats (timeout=%0d) want 2", o_beats, o_timeout);
      end
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (o_data[i] !== want[i] || o_last[i] !== (i == 1) || o_resp[i] !== 2'b00) begin
            tests_failed++;
            $display("FAIL wide_beat%0d: got %h last=%b resp=%b want %h last=%0d resp=00",
                     i, o_data[i], o_last[i], o_resp[i], want[i], i == 1);
         end
      end
      tests_run++;
      if (o_pops !== 4 || o_extra !== 0) begin
         tests_failed++;
         $display("FAIL wide_pops: got %0d pops, %0d extra want 4, 0", o_pops, o_extra);
      end
      tests_run++;
      if (o_latbad !== 0 || o_overlap !== 0) begin
         tests_failed++;
         $display("FAIL wide_timing: got latency errors=%0d overlaps=%0d want 0, 0", o_latbad, o_overlap);
      end
   endtask

   task automatic test_narrow_reuse();
      logic [63:0] want [3];
      clear_q();
      q_words[0] = 32'hAAAABBBB; q_words[1] = 32'hCCCCDDDD;
      nwords = 2;
      want[0] = 64'h00000000AAAABBBB; want[1] = 64'hCCCCDDDD00000000; want[2] = 64'hCCCCDDDD00000000;
      run_burst(3'd2, 3'd1, 8'd2, 0, 0);
      tests_run++;
      if (o_timeout !== 0 || o_beats !== 3) begin
         tests_failed++;
         $display("FAIL narrow_beats: got %0d beats (timeout=%0d) want 3", o_beats, o_timeout);
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (o_data[i] !== want[i] || o_last[i] !== (i == 2)) begin
            tests_failed++;
            $display("FAIL narrow_beat%0d: got %h last=%b want %h last=%0d", i, o_data[i], o_last[i], want[i], i == 2);
         end
      end
      tests_run++;
      if (o_pops !== 2 || o_extra !== 0) begin
         tests_failed++;
         $display("FAIL narrow_pops: got %0d pops, %0d extra want 2, 0", o_pops, o_extra);
      end
   endtask

   task automatic test_byte_top();
      clear_q();
      q_words[0] = 32'h12345678;
      nwords = 1;
      run_burst(3'd7, 3'd0, 8'd0, 0, 0);
      tests_run++;
      if (o_beats !== 1 || o_data[0] !== 64'h1234567800000000 || o_last[0] !== 1'b1 || o_resp[0] !== 2'b00) begin
         tests_failed++;
         $display("FAIL byte_top: got beats=%0d data=%h last=%b resp=%b want 1/1234567800000000/1/00",
                  o_beats, o_data[0], o_last[0], o_resp[0]);
      end
      tests_run++;
      if (o_pops !== 1 || o_extra !== 0 || phy_ready_o !== 1'b0 || axi_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL byte_top_idle: got pops=%0d extra=%0d ready=%b valid=%b want 1/0/0/0",
                  o_pops, o_extra, phy_ready_o, axi_valid_o);
      end
   endtask

   task automatic test_backpressure();
      load_s1();
      run_burst(3'd0, 3'd3, 8'd1, 5, 0);
      tests_run++;
      if (o_unstable !== 0 || o_overlap !== 0) begin
         tests_failed++;
         $display("FAIL bp_stable: got unstable=%0d ready-while-valid=%0d want 0, 0", o_unstable, o_overlap);
      end
      tests_run++;
      if (o_beats !== 2 || o_data[0] !== 64'h2222222211111111 || o_data[1] !== 64'h4444444433333333) begin
         tests_failed++;
         $display("FAIL bp_data: got beats=%0d %h %h want 2 2222222211111111 4444444433333333",
                  o_beats, o_data[0], o_data[1]);
      end
      tests_run++;
      if (o_pops !== 4) begin
         tests_failed++;
         $display("FAIL bp_pops: got %0d want 4", o_pops);
      end
   endtask

   task automatic test_error();
      load_s1();
      q_err[1] = 1'b1;
      run_burst(3'd0, 3'd3, 8'd1, 0, 0);
      tests_run++;
      if (o_beats !== 2 || o_resp[0] !== 2'b10 || o_resp[1] !== 2'b00) begin
         tests_failed++;
         $display("FAIL err_resp: got beats=%0d resp0=%b resp1=%b want 2/10/00", o_beats, o_resp[0], o_resp[1]);
      end
   endtask

   task automatic test_write_ignored();
      @(negedge clk_i);
      trans_handshake = 1'b1; is_a_write = 1'b1; start_addr = '0; size = 3'd3; len = 8'd0;
      @(negedge clk_i);
      trans_handshake = 1'b0; is_a_write = 1'b0;
      tests_run++;
      if (phy_ready_o !== 1'b0 || axi_valid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_ignored: got ready=%b valid=%b want 0/0", phy_ready_o, axi_valid_o);
      end
   endtask

   task automatic test_reset_mid_burst();
      load_s1();
      @(negedge clk_i);
      trans_handshake = 1'b1; start_addr = '0; size = 3'd3; len = 8'd1;
      @(negedge clk_i);
      trans_handshake = 1'b0; phy_valid_i = 1'b1; phy_data_i = q_words[0];
      @(negedge clk_i);
      phy_valid_i = 1'b0; rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      tests_run++;
      if ({phy_ready_o, axi_valid_o, axi_last_o} !== 3'b000 || axi_data_o !== 64'h0 || axi_resp_o !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_mid: got ready/valid/last=%b data=%h resp=%b want 000/0/00",
                  {phy_ready_o, axi_valid_o, axi_last_o}, axi_data_o, axi_resp_o);
      end
      run_burst(3'd0, 3'd3, 8'd1, 0, 0);
      tests_run++;
      if (o_beats !== 2 || o_data[0] !== 64'h2222222211111111 || o_data[1] !== 64'h4444444433333333
          || o_last[1] !== 1'b1 || o_pops !== 4) begin
         tests_failed++;
         $display("FAIL reset_rerun: got beats=%0d %h %h last1=%b pops=%0d want 2 2222222211111111 4444444433333333 1 4",
                  o_beats, o_data[0], o_data[1], o_last[1], o_pops);
      end
   endtask

   task automatic test_random();
      int a, s, l;
      for (int n = 0; n < 40; n++) begin
         clear_q();
         for (int i = 0; i < 64; i++) begin
            q_words[i] = $urandom;
            q_err[i] = ($urandom_range(0, 3) == 0);
         end
         a = $urandom_range(0, 7);
         s = $urandom_range(0, 3);
         l = $urandom_range(0, 5);
         model(a, s, l);
         nwords = e_pops;
         run_burst(3'(a), 3'(s), 8'(l), $urandom_range(0, 3), 1);
         tests_run++;
         if (o_timeout !== 0 || o_beats !== e_beats || o_pops !== e_pops || o_extra !== 0) begin
            tests_failed++;
            $display("FAIL rand%0d_count: got beats=%0d pops=%0d extra=%0d timeout=%0d want %0d/%0d/0/0 (a=%0d s=%0d l=%0d)",
                     n, o_beats, o_pops, o_extra, o_timeout, e_beats, e_pops, a, s, l);
         end
         for (int i = 0; i < o_beats && i < e_beats; i++) begin
            tests_run++;
            if (o_data[i] !== e_data[i] || o_resp[i] !== e_resp[i] || o_last[i] !== e_last[i]) begin
               tests_failed++;
               $display("FAIL rand%0d_beat%0d: got %h resp=%b last=%b want %h resp=%b last=%b (a=%0d s=%0d l=%0d)",
                        n, i, o_data[i], o_resp[i], o_last[i], e_data[i], e_resp[i], e_last[i], a, s, l);
            end
         end
         tests_run++;
         if (o_latbad !== 0 || o_overlap !== 0 || o_unstable !== 0) begin
            tests_failed++;
            $display("FAIL rand%0d_timing: got latency=%0d overlap=%0d unstable=%0d want 0/0/0",
                     n, o_latbad, o_overlap, o_unstable);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_q();
      repeat (3) @(negedge clk_i);
      test_reset();
      rst_i = 1'b0;
      @(negedge clk_i);
      test_wide_aligned();
      test_narrow_reuse();
      test_byte_top();
      test_backpressure();
      test_error();
      test_write_ignored();
      test_reset_mid_burst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
